cpu_mem_bridge: RTL and testbench
=================================

Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the multicycle custom_cpu.
- Merges the CPU's separate instruction-fetch and data-access valid/ready channels onto one shared memory port, with one outstanding transaction at a time.
- Captures each read response in a register and delivers it to whichever CPU channel issued the read.
- Gives the CPU a single-ported memory without changing the CPU's handshake semantics.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses; the strobe width is DATA_WIDTH/8.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low (rst==0 resets)
inst_req_addr  in  ADDR_WIDTH  fetch address (CPU PC)
inst_req_valid  in  1  fetch request valid
inst_req_ready  out  1  bridge accepts the fetch this cycle
inst_rdata  out  DATA_WIDTH  fetched instruction
inst_rvalid  out  1  inst_rdata valid
inst_rready  in  1  CPU takes the instruction
d_addr  in  ADDR_WIDTH  data address
d_memread  in  1  load request
d_memwrite  in  1  store request
d_wdata  in  DATA_WIDTH  store data
d_wstrb  in  DATA_WIDTH/8  store byte enables
d_req_ready  out  1  bridge accepts the data request this cycle
d_rdata  out  DATA_WIDTH  load data
d_rvalid  out  1  d_rdata valid
d_rready  in  1  CPU takes the load data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_addr  out  ADDR_WIDTH  word-aligned address
mem_wen  out  1  1=write, 0=read
mem_wdata  out  DATA_WIDTH  write data
mem_wstrb  out  DATA_WIDTH/8  write strobes
mem_rdata  in  DATA_WIDTH  read data
mem_rvalid  in  1  read data valid
mem_rready  out  1  bridge accepts read data

Behaviour:
- States: IDLE, REQ, RESP, DLV. Reset value: IDLE.
- Registers: req_addr, req_wen, req_wdata, req_wstrb, owner (0=inst, 1=data), rbuf.
- Reset values: all registers 0; every valid/ready output and every data output is 0.
- IDLE, arbitration: the data channel has fixed priority over the instruction channel.
  - d_req_ready = (state==IDLE).
  - inst_req_ready = (state==IDLE) && !d_memread && !d_memwrite.
- Grant, on the cycle a request is accepted:
  - req_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - req_wen = d_memwrite.
  - req_wstrb = d_wstrb for writes, 0 for reads.
  - Update owner; go to REQ.
  - If d_memread and d_memwrite are both high, perform the write only; the read is dropped.
- REQ:
  - mem_req_valid=1; mem_addr/mem_wen/mem_wdata/mem_wstrb are driven from the registers and held stable until mem_req_ready.
  - On mem_req_ready: a write returns to IDLE (no response phase); a read goes to RESP.
- RESP:
  - mem_rready=1.
  - On mem_rvalid: rbuf<=mem_rdata; go to DLV.
- DLV:
  - The channel selected by owner drives rvalid=1; the other channel's rvalid stays 0.
  - inst_rdata = d_rdata = rbuf, stable.
  - On the selected rready: go to IDLE.
- Minimum read latency is 3 cycles from grant to rvalid (grant T0, mem accept T1, mem_rvalid T2, rvalid T3). A write frees the bridge 1 cycle after memory acceptance.
- mem_rvalid outside RESP is ignored; mem_req_ready outside REQ is ignored.
- CPU request inputs are ignored outside IDLE; both req_ready outputs are 0 there.
- Stalls: any number of wait cycles in REQ, RESP or DLV holds all outputs unchanged.
- Reset mid-transaction: immediate return to IDLE; the outstanding memory transaction is abandoned, and the memory side must also be reset.
- A write with d_wstrb==0 is still issued to memory.

Optional Feature:
- Macro: CPU_MEM_BRIDGE_PERF_EN.
- When defined:
  - Adds four 32-bit outputs: perf_inst_cnt, perf_load_cnt, perf_store_cnt and perf_stall_cnt.
  - The first three count granted fetches, loads and stores.
  - perf_stall_cnt counts cycles spent in REQ with mem_req_ready==0 plus cycles in RESP with mem_rvalid==0.
  - All four wrap modulo 2^32 and reset to 0.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
1. Fetch at inst_req_addr=0x0000_0014 with ready memory (mem_rdata=0x0000_0013, 1-cycle response) -> mem_addr=0x14, mem_wen=0, inst_rvalid at T3 with inst_rdata=0x13, d_rvalid stays 0.
2. Same cycle: inst_req_valid=1 and d_memread=1 at d_addr=0x103 -> data granted first, mem_addr=0x100, inst_req_ready=0; the fetch is granted in the first IDLE cycle after d_rready.
3. Store d_addr=0x208, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_req_ready held 0 for 4 cycles -> request fields stay stable for 5 cycles; IDLE the cycle after acceptance; no rvalid on either channel.
4. d_memread=d_memwrite=1 -> exactly one write transaction is issued, no read response; with CPU_MEM_BRIDGE_PERF_EN, perf_store_cnt increments by 1 and perf_load_cnt is unchanged.
5. Read in RESP, mem_rvalid held 0 for 10 cycles, rst driven low asynchronously mid-cycle -> all outputs go to 0 immediately; state is IDLE after rst rises; a new fetch completes normally.
6. Read response arrives while the CPU holds d_rready=0 for 3 cycles -> d_rvalid=1 and d_rdata stable for 4 cycles; mem_rready=0 throughout DLV.

Source files
------------

// File: rtl/cpu_mem_bridge.sv
// Merges the CPU fetch and data channels onto one single-outstanding memory port.
// Optional CPU_MEM_BRIDGE_PERF_EN adds grant and stall counters.
module cpu_mem_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   inst_req_addr,
   input  logic                    inst_req_valid,
   output logic                    inst_req_ready,
   output logic [DATA_WIDTH-1:0]   inst_rdata,
   output logic                    inst_rvalid,
   input  logic                    inst_rready,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic                    d_memread,
   input  logic                    d_memwrite,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic                    d_req_ready,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_rvalid,
   input  logic                    d_rready,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic                    mem_wen,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_rvalid,
   output logic                    mem_rready
`ifdef CPU_MEM_BRIDGE_PERF_EN
   ,
   output logic [31:0]             perf_inst_cnt,
   output logic [31:0]             perf_load_cnt,
   output logic [31:0]             perf_store_cnt,
   output logic [31:0]             perf_stall_cnt
`endif
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, REQ, RESP, DLV} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic                    req_wen;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [STRB_WIDTH-1:0]   req_wstrb;
   logic                    owner;
   logic [DATA_WIDTH-1:0]   rbuf;

   logic d_req;
   logic unused_addr_lsbs;

   assign d_req            = d_memread | d_memwrite;
   assign unused_addr_lsbs = ^{d_addr[1:0], inst_req_addr[1:0]};

   // Request readies are qualified by rst so every ready reads 0 while reset is held.
   assign d_req_ready    = rst && (state == IDLE);
   assign inst_req_ready = rst && (state == IDLE) && !d_req;

   assign mem_addr   = req_addr;
   assign mem_wen    = req_wen;
   assign mem_wdata  = req_wdata;
   assign mem_wstrb  = req_wstrb;
   assign inst_rdata = rbuf;
   assign d_rdata    = rbuf;

   // Transaction FSM; valid/ready outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         req_addr      <= '0;
         req_wen       <= 1'b0;
         req_wdata     <= '0;
         req_wstrb     <= '0;
         owner         <= 1'b0;
         rbuf          <= '0;
         mem_req_valid <= 1'b0;
         mem_rready    <= 1'b0;
         inst_rvalid   <= 1'b0;
         d_rvalid      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req) begin
                  // A combined read+write performs only the write.
                  req_addr      <= {d_addr[ADDR_WIDTH-1:2], 2'b00};
                  req_wen       <= d_memwrite;
                  req_wdata     <= d_memwrite ? d_wdata : '0;
                  req_wstrb     <= d_memwrite ? d_wstrb : '0;
                  owner         <= 1'b1;
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
               end else if (inst_req_valid) begin
                  req_addr      <= {inst_req_addr[ADDR_WIDTH-1:2], 2'b00};
                  req_wen       <= 1'b0;
                  req_wdata     <= '0;
                  req_wstrb     <= '0;
                  owner         <= 1'b0;
                  mem_req_valid <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (req_wen) begin
                     state <= IDLE;
                  end else begin
                     mem_rready <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            RESP: begin
               if (mem_rvalid) begin
                  rbuf       <= mem_rdata;
                  mem_rready <= 1'b0;
                  d_rvalid   <= owner;
                  inst_rvalid <= !owner;
                  state      <= DLV;
               end
            end
            DLV: begin
               if (owner ? d_rready : inst_rready) begin
                  d_rvalid    <= 1'b0;
                  inst_rvalid <= 1'b0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef CPU_MEM_BRIDGE_PERF_EN
   // Grant and memory-wait counters, free-running modulo 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_inst_cnt  <= 32'd0;
         perf_load_cnt  <= 32'd0;
         perf_store_cnt <= 32'd0;
         perf_stall_cnt <= 32'd0;
      end else begin
         if (state == IDLE) begin
            if (d_memwrite)
               perf_store_cnt <= perf_store_cnt + 32'd1;
            else if (d_memread)
               perf_load_cnt <= perf_load_cnt + 32'd1;
            else if (inst_req_valid)
               perf_inst_cnt <= perf_inst_cnt + 32'd1;
         end
         if ((state == REQ && !mem_req_ready) || (state == RESP && !mem_rvalid))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: cycle-exact CPU and memory stimulus.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst_req_addr = '0;
   logic        inst_req_valid = 1'b0;
   logic        inst_req_ready;
   logic [31:0] inst_rdata;
   logic        inst_rvalid;
   logic        inst_rready = 1'b0;
   logic [31:0] d_addr = '0;
   logic        d_memread = 1'b0;
   logic        d_memwrite = 1'b0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_req_ready;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        d_rready = 1'b0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        mem_rready;
`ifdef CPU_MEM_BRIDGE_PERF_EN
   logic [31:0] perf_inst_cnt, perf_load_cnt, perf_store_cnt, perf_stall_cnt;
`endif

   cpu_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req_addr(inst_req_addr), .inst_req_valid(inst_req_valid),
      .inst_req_ready(inst_req_ready), .inst_rdata(inst_rdata),
      .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
      .d_addr(d_addr), .d_memread(d_memread), .d_memwrite(d_memwrite),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_req_ready(d_req_ready),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .mem_rready(mem_rready)
`ifdef CPU_MEM_BRIDGE_PERF_EN
      , .perf_inst_cnt(perf_inst_cnt), .perf_load_cnt(perf_load_cnt),
      .perf_store_cnt(perf_store_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct {
      logic        owner;
      logic [31:0] data;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Memory-side request fields against the head of the request queue.
   task automatic check_req(input string tag);
      req_t e;
      if (req_q.size() == 0) begin
         check({tag, "_req_q_empty"}, 1, 0);
         return;
      end
      e = req_q[0];
      check({tag, "_mem_req_valid"}, mem_req_valid, 1);
      check({tag, "_mem_addr"}, mem_addr, e.addr);
      check({tag, "_mem_wen"}, mem_wen, e.wen);
      check({tag, "_mem_wstrb"}, mem_wstrb, e.wstrb);
      if (e.wen) check({tag, "_mem_wdata"}, mem_wdata, e.wdata);
      check({tag, "_busy_d_req_ready"}, d_req_ready, 0);
      check({tag, "_busy_inst_req_ready"}, inst_req_ready, 0);
      check({tag, "_req_rvalids"}, {inst_rvalid, d_rvalid}, 0);
   endtask

   task automatic do_read(input logic is_inst, input logic [31:0] addr, input logic [31:0] rdata,
                          input int req_stall, input int resp_stall, input int dlv_stall,
                          input logic abort);
      rsp_t e;
      if (is_inst) begin
         inst_req_addr  = addr;
         inst_req_valid = 1'b1;
      end else begin
         d_addr    = addr;
         d_memread = 1'b1;
      end
      req_q.push_back('{addr & 32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0});
      rsp_q.push_back('{!is_inst, rdata});
      #1;
      if (is_inst) begin
         check("fetch_grant_ready", inst_req_ready, 1);
      end else begin
         check("load_grant_ready", d_req_ready, 1);
         if (inst_req_valid) check("inst_blocked_by_data", inst_req_ready, 0);
      end
      tick();
      if (is_inst) inst_req_valid = 1'b0;
      else d_memread = 1'b0;
      d_addr = ~addr;
      for (int i = 0; i <= req_stall; i++) begin
         mem_req_ready = (i == req_stall);
         mem_rvalid    = 1'b1;
         #1;
         check_req("rd");
         check("rd_req_mem_rready", mem_rready, 0);
         tick();
      end
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      void'(req_q.pop_front());
      for (int i = 0; i < resp_stall; i++) begin
         mem_req_ready = 1'b1;
         #1;
         check("resp_mem_rready", mem_rready, 1);
         check("resp_mem_req_valid", mem_req_valid, 0);
         check("resp_rvalids", {inst_rvalid, d_rvalid}, 0);
         tick();
      end
      mem_req_ready = 1'b0;
      if (abort) begin
         #2 rst = 1'b0;
         #1;
         check("rst_outs_valid", {mem_req_valid, mem_rready, inst_rvalid, d_rvalid}, 0);
         check("rst_outs_ready", {d_req_ready, inst_req_ready}, 0);
         check("rst_outs_data", {inst_rdata, mem_addr}, 0);
         rsp_q.delete();
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("post_rst_idle", {d_req_ready, mem_req_valid, mem_rready}, 3'b100);
         return;
      end
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      #1;
      check("resp_accept_mem_rready", mem_rready, 1);
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = ~rdata;
      e = rsp_q.pop_front();
      for (int i = 0; i <= dlv_stall; i++) begin
         // Non-owner rready is asserted to show it is ignored.
         inst_rready = e.owner ? 1'b1 : (i == dlv_stall);
         d_rready    = e.owner ? (i == dlv_stall) : 1'b1;
         #1;
         check("dlv_inst_rvalid", inst_rvalid, !e.owner);
         check("dlv_d_rvalid", d_rvalid, e.owner);
         check("dlv_rdata", e.owner ? d_rdata : inst_rdata, e.data);
         check("dlv_mem_side", {mem_rready, mem_req_valid, d_req_ready}, 0);
         tick();
      end
      inst_rready = 1'b0;
      d_rready    = 1'b0;
      #1;
      check("dlv_done_idle", {d_req_ready, inst_rvalid, d_rvalid}, 3'b100);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int req_stall, input logic also_read);
      d_addr     = addr;
      d_wdata    = wdata;
      d_wstrb    = wstrb;
      d_memwrite = 1'b1;
      d_memread  = also_read;
      req_q.push_back('{addr & 32'hFFFF_FFFC, 1'b1, wdata, wstrb});
      #1;
      check("store_grant_ready", d_req_ready, 1);
      check("store_inst_blocked", inst_req_ready, 0);
      tick();
      d_memwrite = 1'b0;
      d_memread  = 1'b0;
      d_wdata    = ~wdata;
      d_wstrb    = ~wstrb;
      for (int i = 0; i <= req_stall; i++) begin
         mem_req_ready = (i == req_stall);
         #1;
         check_req("wr");
         tick();
      end
      mem_req_ready = 1'b0;
      void'(req_q.pop_front());
      mem_rvalid = 1'b1;
      #1;
      check("wr_done_idle", {d_req_ready, mem_req_valid, mem_rready}, 3'b100);
      check("wr_no_rvalid", {inst_rvalid, d_rvalid}, 0);
      tick();
      mem_rvalid = 1'b0;
      #1;
      check("wr_stray_rvalid_ignored", {d_req_ready, mem_rready, inst_rvalid, d_rvalid}, 4'b1000);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CPU_MEM_BRIDGE_PERF_EN
      logic [31:0] st0, ld0;
`endif
      @(negedge clk);
      #1;
      check("reset_valids", {mem_req_valid, mem_rready, inst_rvalid, d_rvalid}, 0);
      check("reset_readies", {d_req_ready, inst_req_ready}, 0);
      check("reset_data", {inst_rdata, d_rdata}, 0);
      check("reset_mem_fields", {mem_addr, mem_wen, mem_wstrb}, 0);
      rst = 1'b1;
      #1;
      check("idle_readies", {d_req_ready, inst_req_ready}, 2'b11);
      @(negedge clk);

      do_read(1'b1, 32'h0000_0014, 32'h0000_0013, 0, 0, 0, 1'b0);

      inst_req_addr  = 32'h0000_0040;
      inst_req_valid = 1'b1;
      do_read(1'b0, 32'h0000_0103, 32'hCAFE_0001, 1, 1, 0, 1'b0);
      do_read(1'b1, 32'h0000_0040, 32'h0000_0093, 0, 2, 1, 1'b0);

      do_write(32'h0000_0208, 32'hDEAD_BEEF, 4'b0011, 4, 1'b0);
      do_write(32'h0000_0210, 32'h0BAD_F00D, 4'b0000, 0, 1'b0);

`ifdef CPU_MEM_BRIDGE_PERF_EN
      st0 = perf_store_cnt;
      ld0 = perf_load_cnt;
`endif
      do_write(32'h0000_020E, 32'h1234_5678, 4'b1111, 1, 1'b1);
`ifdef CPU_MEM_BRIDGE_PERF_EN
      check("perf_store_inc", perf_store_cnt, st0 + 32'd1);
      check("perf_load_same", perf_load_cnt, ld0);
`endif

      do_read(1'b1, 32'h0000_0050, 32'h1111_2222, 0, 10, 0, 1'b1);
      do_read(1'b1, 32'h0000_0054, 32'h3333_4444, 0, 0, 0, 1'b0);

      do_read(1'b0, 32'h0000_0300, 32'hA5A5_5A5A, 0, 0, 3, 1'b0);

      for (int k = 0; k < 8; k++) begin
         logic [31:0] a, v;
         a = $urandom;
         v = $urandom;
         if (k % 3 == 2)
            do_write(a, v, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0);
         else
            do_read(1'(k % 2), a, v, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0);
      end
      check("scoreboard_drained", req_q.size() + rsp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
